// File: rtl/cva6_lsu_issue_buffer_if.sv
// Issue-stage / retire-stage / LSU signal bundle for cva6_lsu_issue_buffer.
// Optional stats outputs exist only when LSU_ISSUE_STATS_EN is defined.
interface cva6_lsu_issue_buffer_if #(
    parameter int DEPTH           = 4,
    parameter int MAX_UNCOMMITTED = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int UNC_W = $clog2(MAX_UNCOMMITTED) + 1;

    // Upstream handshake: a word transfers on a clock edge where in_valid_i && in_ready_o;
    // in_valid_i may rise without waiting for ready, and the word must stay stable until taken.
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_instr_i;
    logic             in_is_load_i;
    logic             flush_i;
    logic             commit_i;
    logic             lsu_ready_i;
    logic             instr_valid_o;
    logic [31:0]      instr_o;
    logic             is_load_o;
    logic             store_commit_o;
    logic [OCC_W-1:0] occupancy_o;
    logic [UNC_W-1:0] uncommitted_o;
    logic             commit_err_o;
    logic [1:0]       state_o;
`ifdef LSU_ISSUE_STATS_EN
    logic [15:0]      stat_loads_o;
    logic [15:0]      stat_stores_o;
`endif

    modport slave (
        input  in_valid_i, in_instr_i, in_is_load_i, flush_i, commit_i, lsu_ready_i,
        output in_ready_o, instr_valid_o, instr_o, is_load_o, store_commit_o,
               occupancy_o, uncommitted_o, commit_err_o, state_o
`ifdef LSU_ISSUE_STATS_EN
        , output stat_loads_o, stat_stores_o
`endif
    );

    modport master (
        output in_valid_i, in_instr_i, in_is_load_i, flush_i, commit_i, lsu_ready_i,
        input  in_ready_o, instr_valid_o, instr_o, is_load_o, store_commit_o,
               occupancy_o, uncommitted_o, commit_err_o, state_o
`ifdef LSU_ISSUE_STATS_EN
        , input stat_loads_o, stat_stores_o
`endif
    );
endinterface

// File: rtl/cva6_lsu_issue_buffer.sv
// FIFO-buffered, rate-limited issue of memory instructions to the CVA6 LSU with store-commit tracking.
// Define LSU_ISSUE_STATS_EN to add issued load/store counters.
module cva6_lsu_issue_buffer #(
    parameter int DEPTH           = 4,
    parameter int MIN_GAP         = 3,
    parameter int MAX_UNCOMMITTED = 4
) (
    input logic clk_i,
    input logic rst_i,
    cva6_lsu_issue_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int UW = $clog2(MAX_UNCOMMITTED) + 1;
    localparam int GW = $clog2(MIN_GAP + 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [UW-1:0] UNC_MAX  = UW'(MAX_UNCOMMITTED);
    localparam logic [GW-1:0] GAP_INIT = GW'(MIN_GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t        state;
    logic [32:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic [GW-1:0] gap_ctr;
    logic [UW-1:0] uncommitted_q;
    logic [31:0]   instr_q, head_instr;
    logic          instr_valid_q, is_load_q, store_commit_q, commit_err_q;
    logic          full, empty, push, head_load, cap_ok, issue_go, issue_store, commit_acc;

    assign count       = wr_ptr - rd_ptr;
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign push        = bus.in_valid_i && !full && !bus.flush_i;
    assign {head_load, head_instr} = mem[rd_ptr[AW-1:0]];
    assign cap_ok      = head_load || (uncommitted_q < UNC_MAX);
    // The last WAIT cycle doubles as the IDLE decision cycle so pulses sit exactly MIN_GAP+1 apart.
    assign issue_go    = ((state == IDLE) || (state == WAIT && gap_ctr == GAP_LAST)) &&
                         !empty && bus.lsu_ready_i && !bus.flush_i && cap_ok;
    assign issue_store = issue_go && !head_load;
    assign commit_acc  = bus.commit_i && (uncommitted_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.in_is_load_i, bus.in_instr_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            gap_ctr        <= '0;
            uncommitted_q  <= '0;
            instr_valid_q  <= 1'b0;
            instr_q        <= '0;
            is_load_q      <= 1'b0;
            store_commit_q <= 1'b0;
            commit_err_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (bus.flush_i) rd_ptr <= wr_ptr;
            else if (issue_go) rd_ptr <= rd_ptr + 1'b1;

            uncommitted_q  <= uncommitted_q + UW'(issue_store) - UW'(commit_acc);
            store_commit_q <= commit_acc;
            if (bus.commit_i && !commit_acc) commit_err_q <= 1'b1;

            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            if (issue_go) begin
                state         <= ISSUE;
                instr_valid_q <= 1'b1;
                instr_q       <= head_instr;
                is_load_q     <= head_load;
            end else begin
                case (state)
                    ISSUE: begin
                        state   <= WAIT;
                        gap_ctr <= GAP_INIT;
                    end
                    WAIT: begin
                        if (gap_ctr == GAP_LAST) state <= IDLE;
                        else gap_ctr <= gap_ctr - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LSU_ISSUE_STATS_EN
    logic [15:0] stat_loads_q, stat_stores_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
        end else if (state == ISSUE) begin
            if (is_load_q) stat_loads_q <= stat_loads_q + 16'd1;
            else stat_stores_q <= stat_stores_q + 16'd1;
        end
    end

    assign bus.stat_loads_o  = stat_loads_q;
    assign bus.stat_stores_o = stat_stores_q;
`endif

    assign bus.in_ready_o     = !full;
    assign bus.instr_valid_o  = instr_valid_q;
    assign bus.instr_o        = instr_q;
    assign bus.is_load_o      = is_load_q;
    assign bus.store_commit_o = store_commit_q;
    assign bus.occupancy_o    = count;
    assign bus.uncommitted_o  = uncommitted_q;
    assign bus.commit_err_o   = commit_err_q;
    assign bus.state_o        = state;
endmodule

// File: tb/tb_cva6_lsu_issue_buffer.sv
// Directed self-checking bench for cva6_lsu_issue_buffer (DEPTH=4, MIN_GAP=3, MAX_UNCOMMITTED=4).
// Stats checks are included when LSU_ISSUE_STATS_EN is defined.
module tb_cva6_lsu_issue_buffer;
    localparam int DEPTH   = 4;
    localparam int MIN_GAP = 3;
    localparam int MAX_UNC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cva6_lsu_issue_buffer_if #(.DEPTH(DEPTH), .MAX_UNCOMMITTED(MAX_UNC)) bus ();

    cva6_lsu_issue_buffer #(.DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .MAX_UNCOMMITTED(MAX_UNC)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [63:0] exp_q[$];
    int          issue_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w, input logic ld, input logic track);
        bus.in_valid_i   = 1'b1;
        bus.in_instr_i   = w;
        bus.in_is_load_i = ld;
        if (track) exp_q.push_back({31'b0, ld, w});
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every issue pulse must match the oldest expected word, in order.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && bus.instr_valid_o) begin
            issue_cyc.push_back(cyc);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check("issue_word", 64'({bus.is_load_o, bus.instr_o}), e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid_i   = 1'b0;
        bus.in_instr_i   = '0;
        bus.in_is_load_i = 1'b0;
        bus.flush_i      = 1'b0;
        bus.commit_i     = 1'b0;
        bus.lsu_ready_i  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        check("rst_occ", 64'(bus.occupancy_o), 64'(0));
        check("rst_unc", 64'(bus.uncommitted_o), 64'(0));
        check("rst_err", 64'(bus.commit_err_o), 64'(0));
        check("rst_valid", 64'(bus.instr_valid_o), 64'(0));
        check("rst_instr", 64'(bus.instr_o), 64'(0));
        check("rst_is_load", 64'(bus.is_load_o), 64'(0));
        check("rst_commit", 64'(bus.store_commit_o), 64'(0));
        check("rst_state", 64'(bus.state_o), 64'(0));
        check("rst_ready", 64'(bus.in_ready_o), 64'(1));

        // Single store: pulse two cycles after it is presented
        bus.lsu_ready_i = 1'b1;
        push(32'h0000_1000, 1'b0, 1'b1);
        check("lat_early", 64'(bus.instr_valid_o), 64'(0));
        tick();
        check("lat_pulse", 64'(bus.instr_valid_o), 64'(1));
        check("lat_is_load", 64'(bus.is_load_o), 64'(0));
        check("lat_unc", 64'(bus.uncommitted_o), 64'(1));
        tick();
        check("pulse_end", 64'(bus.instr_valid_o), 64'(0));
        check("pulse_instr0", 64'(bus.instr_o), 64'(0));
        check("state_wait", 64'(bus.state_o), 64'(2));
        bus.commit_i = 1'b1;
        tick();
        bus.commit_i = 1'b0;
        check("commit1_pulse", 64'(bus.store_commit_o), 64'(1));
        check("commit1_unc", 64'(bus.uncommitted_o), 64'(0));
        tick();
        check("commit1_end", 64'(bus.store_commit_o), 64'(0));
        repeat (4) tick();

        // Fill with LSU not ready; fifth word held upstream; then pulses 4 cycles apart
        bus.lsu_ready_i = 1'b0;
        issue_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 64'(bus.in_ready_o), 64'(1));
            push(32'h0000_00A0 + 32'(i), 1'b1, 1'b1);
        end
        check("full_ready", 64'(bus.in_ready_o), 64'(0));
        check("full_occ", 64'(bus.occupancy_o), 64'(4));
        bus.in_valid_i   = 1'b1;
        bus.in_instr_i   = 32'h0000_00A4;
        bus.in_is_load_i = 1'b1;
        exp_q.push_back({31'b0, 1'b1, 32'h0000_00A4});
        tick();
        check("held_occ", 64'(bus.occupancy_o), 64'(4));
        bus.lsu_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (bus.in_ready_o) begin
                tick();
                break;
            end
            tick();
        end
        bus.in_valid_i = 1'b0;
        repeat (30) tick();
        check("spacing_count", 64'(issue_cyc.size()), 64'(5));
        for (int i = 0; i + 1 < issue_cyc.size(); i++)
            check("spacing", 64'(issue_cyc[i+1] - issue_cyc[i]), 64'(MIN_GAP + 1));

        // Store cap: four stores issue, fifth stalls until one commit
        bus.lsu_ready_i = 1'b0;
        issue_cyc.delete();
        for (int i = 0; i < 4; i++) push(32'h0000_5000 + 32'(i), 1'b0, 1'b1);
        bus.lsu_ready_i = 1'b1;
        repeat (20) tick();
        check("cap_unc", 64'(bus.uncommitted_o), 64'(4));
        push(32'h0000_5004, 1'b0, 1'b1);
        repeat (8) tick();
        check("cap_stall_count", 64'(issue_cyc.size()), 64'(4));
        check("cap_stall_occ", 64'(bus.occupancy_o), 64'(1));
        bus.commit_i = 1'b1;
        tick();
        bus.commit_i = 1'b0;
        check("cap_commit_pulse", 64'(bus.store_commit_o), 64'(1));
        check("cap_commit_unc", 64'(bus.uncommitted_o), 64'(3));
        check("cap_not_yet", 64'(bus.instr_valid_o), 64'(0));
        tick();
        check("cap_release", 64'(bus.instr_valid_o), 64'(1));
        check("cap_release_unc", 64'(bus.uncommitted_o), 64'(4));
        check("cap_commit_end", 64'(bus.store_commit_o), 64'(0));

        // Load behind a stalled store stays behind it; flush beats a same-cycle push
        push(32'h0000_5005, 1'b0, 1'b0);
        push(32'hABCD_0000, 1'b1, 1'b0);
        repeat (8) tick();
        check("order_occ", 64'(bus.occupancy_o), 64'(2));
        check("order_count", 64'(issue_cyc.size()), 64'(5));
        bus.flush_i      = 1'b1;
        bus.in_valid_i   = 1'b1;
        bus.in_instr_i   = 32'hDEAD_0001;
        bus.in_is_load_i = 1'b1;
        tick();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("flush_occ", 64'(bus.occupancy_o), 64'(0));
        check("flush_unc", 64'(bus.uncommitted_o), 64'(4));
        bus.commit_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("b2b_pulse", 64'(bus.store_commit_o), 64'(1));
            check("b2b_unc", 64'(bus.uncommitted_o), 64'(3 - k));
        end
        bus.commit_i = 1'b0;
        tick();
        check("b2b_end", 64'(bus.store_commit_o), 64'(0));
        repeat (6) tick();
        check("flush_no_issue", 64'(issue_cyc.size()), 64'(5));

        // Commit with nothing outstanding
        bus.commit_i = 1'b1;
        tick();
        bus.commit_i = 1'b0;
        check("err_no_pulse", 64'(bus.store_commit_o), 64'(0));
        check("err_set", 64'(bus.commit_err_o), 64'(1));
        check("err_unc", 64'(bus.uncommitted_o), 64'(0));
        repeat (3) tick();
        check("err_sticky", 64'(bus.commit_err_o), 64'(1));

        // Reset mid-WAIT with two entries still queued
        bus.lsu_ready_i = 1'b0;
        push(32'h0000_2100, 1'b1, 1'b1);
        push(32'h0000_2200, 1'b1, 1'b0);
        push(32'h0000_2300, 1'b1, 1'b0);
        bus.lsu_ready_i = 1'b1;
        tick();
        check("mid_pulse", 64'(bus.instr_valid_o), 64'(1));
        tick();
        check("mid_state", 64'(bus.state_o), 64'(2));
        check("mid_occ", 64'(bus.occupancy_o), 64'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_occ", 64'(bus.occupancy_o), 64'(0));
        check("mid_rst_state", 64'(bus.state_o), 64'(0));
        check("mid_rst_valid", 64'(bus.instr_valid_o), 64'(0));
        check("mid_rst_instr", 64'(bus.instr_o), 64'(0));
        check("mid_rst_is_load", 64'(bus.is_load_o), 64'(0));
        check("mid_rst_commit", 64'(bus.store_commit_o), 64'(0));
        check("mid_rst_err", 64'(bus.commit_err_o), 64'(0));
`ifdef LSU_ISSUE_STATS_EN
        check("stat_rst_loads", 64'(bus.stat_loads_o), 64'(0));
        check("stat_rst_stores", 64'(bus.stat_stores_o), 64'(0));
`endif

        // Mixed stream: 3 loads, 2 stores
        push(32'h0000_3000, 1'b1, 1'b1);
        repeat (5) tick();
        push(32'h0000_3100, 1'b0, 1'b1);
        repeat (5) tick();
        push(32'h0000_3200, 1'b1, 1'b1);
        repeat (5) tick();
        push(32'h0000_3300, 1'b0, 1'b1);
        repeat (5) tick();
        push(32'h0000_3400, 1'b1, 1'b1);
        repeat (6) tick();
        check("mix_unc", 64'(bus.uncommitted_o), 64'(2));
`ifdef LSU_ISSUE_STATS_EN
        check("stat_loads", 64'(bus.stat_loads_o), 64'(3));
        check("stat_stores", 64'(bus.stat_stores_o), 64'(2));
`endif

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
